timer: RTL and testbench

Programmable 32-bit down-counting timer on the CPU's peripheral bus. It is the interrupt source at the other end of the coprocessor-0 hardware-interrupt path. Software programs PRESET and CTRL through bus writes. On expiry the block raises `irq`, which the top level wires to `hw_int[2]` of the coprocessor. Two modes: one-shot, where the interrupt is held until software acknowledges it, and auto-reload, where the interrupt is a periodic one-cycle pulse.

---
 rtl/timer_pkg.sv | 42 ++++
 rtl/timer.sv | 111 +++++++++++
 tb/tb_timer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the programmable down-counting timer: register
// address map, CTRL bit layout, MODE encodings and FSM state encoding.
// ---------------------------------------------------------------------------
package timer_pkg;

  // Word addresses (byte-address bits [3:2]); address 3 is reserved.
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  // CTRL bit positions.
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IM_BIT   = 3;
  localparam int CTRL_WIDTH    = 4;

  // MODE encodings; 10/11 fall back to one-shot behaviour.
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // Implemented CTRL bits; packed so bit 0 is EN and bit 3 is IM.
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  // Only the exact auto-reload code reloads; every other code is one-shot.
  function automatic logic is_auto_reload(input logic [1:0] mode);
    return (mode == MODE_RELOAD);
  endfunction

endpackage

// File: rtl/timer.sv
// ---------------------------------------------------------------------------
// timer
// 32-bit programmable down-counting timer on the peripheral bus. Raises irq
// on expiry; one-shot mode holds the request until software acknowledges it
// with a CTRL/PRESET write, auto-reload mode emits a one-cycle pulse every
// PRESET+3 cycles.
//
// Ports:
//   clk       in   1   system clock, rising edge
//   rst       in   1   asynchronous active-high reset
//   addr      in   2   word select: 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved
//   we        in   1   bus write strobe
//   data_in   in  32   write data
//   data_out  out 32   combinational read of the selected register
//   irq       out  1   interrupt request (pending & IM)
// ---------------------------------------------------------------------------
module timer
  import timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        irq
);

  ctrl_t       r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_pending;
  state_e      r_state;
  state_e      w_state_next;

  logic w_ctrl_wr;
  logic w_preset_wr;
  logic w_auto;
  logic w_expire;

  assign w_ctrl_wr   = we && (addr == ADDR_CTRL);
  assign w_preset_wr = we && (addr == ADDR_PRESET);
  assign w_auto      = is_auto_reload(r_ctrl.mode);
  // Counting reached zero while still enabled: the edge that enters INT.
  assign w_expire    = (r_state == ST_CNT) && r_ctrl.en && (r_count == 32'd0);

  // NOTE: every signal assigned in an always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (r_ctrl.en) w_state_next = ST_LOAD;
      ST_LOAD: w_state_next = ST_CNT;
      ST_CNT: begin
        if (!r_ctrl.en)             w_state_next = ST_IDLE;
        else if (r_count == 32'd0)  w_state_next = ST_INT;
      end
      ST_INT:  w_state_next = w_auto ? ST_LOAD : ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ctrl    <= '0;
      r_preset  <= '0;
      r_count   <= '0;
      r_pending <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if (w_preset_wr) r_preset <= data_in;

      // A CTRL write in the same cycle as the one-shot EN clear wins.
      if (w_ctrl_wr)
        r_ctrl <= ctrl_t'(data_in[CTRL_WIDTH-1:0]);
      else if ((r_state == ST_INT) && !w_auto)
        r_ctrl.en <= 1'b0;

      // COUNT loads in LOAD, decrements in CNT while enabled, never wraps.
      if (r_state == ST_LOAD)
        r_count <= r_preset;
      else if ((r_state == ST_CNT) && r_ctrl.en && (r_count != 32'd0))
        r_count <= r_count - 32'd1;

      // Set has priority over acknowledge so no expiry is lost.
      if (w_expire)
        r_pending <= 1'b1;
      else if (w_ctrl_wr || w_preset_wr)
        r_pending <= 1'b0;
      else if ((r_state == ST_INT) && w_auto)
        r_pending <= 1'b0;
    end
  end

  assign irq = r_pending & r_ctrl.im;

  always_comb begin
    data_out = '0;
    case (addr)
      ADDR_CTRL:   data_out = {{(32-CTRL_WIDTH){1'b0}}, r_ctrl};
      ADDR_PRESET: data_out = r_preset;
      ADDR_COUNT:  data_out = r_count;
      default:     data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_timer.sv
// ---------------------------------------------------------------------------
// tb_timer
// Directed bench for the timer. Inputs change and outputs are sampled just
// after the falling edge; a write driven there lands on the next rising edge.
// ---------------------------------------------------------------------------
module tb_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  timer dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .we       (we),
    .data_in  (data_in),
    .data_out (data_out),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called just after a falling edge; the write happens on the next rising
  // edge and the task returns at the falling edge after it.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    addr    = a;
    data_in = d;
    we      = 1'b1;
    @(negedge clk);
    we      = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = data_out;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] v;
  logic [31:0] exp_cnt;

  initial begin
    // Reset state.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    rd(2'd0, v); check("rst_ctrl", v, 32'h0);
    rd(2'd1, v); check("rst_preset", v, 32'h0);
    rd(2'd2, v); check("rst_count", v, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    tick(1);

    // One-shot, PRESET=5: irq rises after edge N+8 and holds.
    bus_write(2'd1, 32'd5);
    bus_write(2'd0, 32'h9);          // edge N
    tick(7);
    check("os_irq_early", {31'b0, irq}, 32'h0);
    tick(1);
    check("os_irq_rise", {31'b0, irq}, 32'h1);
    rd(2'd2, v); check("os_count0", v, 32'h0);
    tick(1);                         // after N+9: EN cleared
    rd(2'd0, v); check("os_ctrl_en_clr", v, 32'h8);
    tick(4);
    check("os_irq_held", {31'b0, irq}, 32'h1);
    bus_write(2'd0, 32'h8);
    check("os_irq_ack", {31'b0, irq}, 32'h0);
    tick(2);

    // Auto-reload, PRESET=3: one-cycle pulse after edges N+6, N+12, N+18.
    bus_write(2'd1, 32'd3);
    bus_write(2'd0, 32'hB);          // edge N
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      check($sformatf("ar_irq_k%0d", k), {31'b0, irq},
            {31'b0, (k >= 6) && ((k - 6) % 6 == 0)});
      if (k >= 2) begin
        case ((k - 2) % 6)
          0: exp_cnt = 32'd3;
          1: exp_cnt = 32'd2;
          2: exp_cnt = 32'd1;
          default: exp_cnt = 32'd0;
        endcase
        rd(2'd2, v); check($sformatf("ar_cnt_k%0d", k), v, exp_cnt);
      end
    end
    bus_write(2'd0, 32'h0);
    tick(3);

    // Masked: pending sets, irq stays low, CTRL write acknowledges.
    bus_write(2'd1, 32'd2);
    bus_write(2'd0, 32'h1);          // edge N, expiry at N+5
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      check($sformatf("mask_irq_k%0d", k), {31'b0, irq}, 32'h0);
    end
    rd(2'd2, v); check("mask_count0", v, 32'h0);
    rd(2'd0, v); check("mask_ctrl", v, 32'h0);
    tick(1);
    bus_write(2'd0, 32'h8);
    check("mask_ack_irq", {31'b0, irq}, 32'h0);
    tick(3);
    check("mask_ack_irq_late", {31'b0, irq}, 32'h0);

    // Disable mid-count: COUNT=6 after N+6; EN=0 lands at N+7 -> freezes at 5.
    bus_write(2'd1, 32'd10);
    bus_write(2'd0, 32'h9);          // edge N
    tick(6);
    rd(2'd2, v); check("dis_count6", v, 32'd6);
    bus_write(2'd0, 32'h8);
    rd(2'd2, v); check("dis_count5", v, 32'd5);
    tick(15);
    rd(2'd2, v); check("dis_frozen", v, 32'd5);
    rd(2'd0, v); check("dis_ctrl", v, 32'h8);
    check("dis_irq", {31'b0, irq}, 32'h0);
    tick(1);

    // PRESET=0: expiry after edge N+3, not earlier.
    bus_write(2'd1, 32'd0);
    bus_write(2'd0, 32'h9);          // edge N
    tick(2);
    check("p0_irq_early", {31'b0, irq}, 32'h0);
    tick(1);
    check("p0_irq_rise", {31'b0, irq}, 32'h1);
    bus_write(2'd1, 32'd0);
    check("p0_ack", {31'b0, irq}, 32'h0);

    // PRESET write during CNT leaves COUNT alone.
    bus_write(2'd1, 32'd20);
    bus_write(2'd0, 32'h1);          // edge N, COUNT=20 after N+2
    tick(2);
    bus_write(2'd1, 32'd100);        // edge N+3 -> COUNT 19
    rd(2'd2, v); check("pwr_count", v, 32'd19);
    bus_write(2'd0, 32'h0);
    tick(2);

    // Asynchronous reset mid-count: COUNT=4 after N+5.
    bus_write(2'd1, 32'd7);
    bus_write(2'd0, 32'h9);          // edge N
    tick(5);
    rd(2'd2, v); check("rstm_count4", v, 32'd4);
    rst = 1'b1;                      // mid-cycle, no clock edge before reads
    rd(2'd0, v); check("rstm_ctrl", v, 32'h0);
    rd(2'd1, v); check("rstm_preset", v, 32'h0);
    rd(2'd2, v); check("rstm_count", v, 32'h0);
    check("rstm_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      check($sformatf("rstm_quiet_k%0d", k), {31'b0, irq}, 32'h0);
    end
    rd(2'd2, v); check("rstm_count_after", v, 32'h0);
    tick(1);

    // Ignored writes: freeze COUNT at 7, then poke COUNT/reserved/CTRL.
    bus_write(2'd1, 32'd9);
    bus_write(2'd0, 32'h1);          // edge N, COUNT=9 after N+2
    tick(3);                         // COUNT=8 after N+3
    bus_write(2'd0, 32'h0);          // edge N+4 -> COUNT 7, then IDLE
    tick(2);
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_write(2'd3, 32'hFFFF_FFFF);
    rd(2'd2, v); check("ign_count", v, 32'd7);
    rd(2'd3, v); check("ign_rsvd", v, 32'h0);
    rd(2'd1, v); check("ign_preset", v, 32'd9);
    tick(1);
    bus_write(2'd0, 32'hFFFF_FFF0);
    rd(2'd0, v); check("ign_ctrl_hi", v, 32'h0);
    tick(3);
    rd(2'd2, v); check("ign_count_hold", v, 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
